// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the truth-table evaluator and its sweep engine.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_TT_4 = 16'h7EE0;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/lut_read.sv
// Combinational 2^N-to-1 truth-table read: val_o = tt_i[idx_i].
module lut_read
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [(2**N)-1:0] tt_i,
  input  logic [N-1:0]      idx_i,
  output logic              val_o
);

  localparam int unsigned TW = tt_width(N);

  logic [TW-1:0] tt_w;

  assign tt_w  = tt_i;
  assign val_o = tt_w[idx_i];

endmodule

// File: rtl/lut_sweep_eval.sv
// Programmable N-input Boolean function: writable truth table, registered direct
// evaluation, and a sweep engine streaming (index, value) beats with minterm counting.
module lut_sweep_eval
  import lut_sweep_pkg::*;
#(
  parameter int unsigned       N          = 4,
  parameter logic [(2**N)-1:0] DEFAULT_TT = DEFAULT_TT_4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tt_wr,
  input  logic [(2**N)-1:0] tt_data,
  input  logic [N-1:0]      eval_in,
  output logic              eval_out,
  input  logic              start,
  input  logic              skip_zeros,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_index,
  output logic              out_value,
  output logic              done,
  output logic [N:0]        ones_count
);

  localparam int unsigned TW     = tt_width(N);
  localparam logic [N-1:0] IdxOne  = N'(1);
  localparam logic [N-1:0] IdxLast = {N{1'b1}};
  localparam logic [N:0]   CntOne  = (N + 1)'(1);

  state_e        state_q, state_d;
  logic [TW-1:0] tt_q, tt_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [N:0]    cnt_q, cnt_d;
  logic          skip_q, skip_d;
  logic          eval_q;

  logic eval_val;
  logic sweep_val;
  logic in_sweep;
  logic accept;
  logic advance;

  lut_read #(
    .N(N)
  ) u_eval_read (
    .tt_i (tt_q),
    .idx_i(eval_in),
    .val_o(eval_val)
  );

  lut_read #(
    .N(N)
  ) u_sweep_read (
    .tt_i (tt_q),
    .idx_i(idx_q),
    .val_o(sweep_val)
  );

  assign in_sweep = (state_q == SWEEP);
  // In on-set mode a zero entry is never presented; it is skipped without a handshake.
  assign out_valid = in_sweep && (skip_q ? sweep_val : 1'b1);
  assign accept    = out_valid && out_ready;
  assign advance   = accept || (in_sweep && skip_q && !sweep_val);

  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;

    // Table is locked while sweeping so every beat reflects one consistent function.
    if (tt_wr && (state_q != SWEEP)) begin
      tt_d = tt_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          skip_d  = skip_zeros;
        end
      end
      SWEEP: begin
        if (accept && sweep_val) begin
          cnt_d = cnt_q + CntOne;
        end
        if (advance) begin
          if (idx_q == IdxLast) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tt_q    <= DEFAULT_TT;
      idx_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eval_q <= 1'b0;
    end else begin
      eval_q <= eval_val;
    end
  end

  assign eval_out   = eval_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign out_index  = idx_q;
  assign out_value  = sweep_val;
  assign ones_count = cnt_q;

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Directed, table-driven bench for lut_sweep_eval (N=4, default table 16'h7EE0).
module tb_lut_sweep_eval;

  logic        clk;
  logic        rst;
  logic        tt_wr;
  logic [15:0] tt_data;
  logic [3:0]  eval_in;
  logic        eval_out;
  logic        start;
  logic        skip_zeros;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_value;
  logic        done;
  logic [4:0]  ones_count;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] in;
    logic       exp;
  } eval_vec_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       val;
  } beat_t;

  beat_t beats[$];

  lut_sweep_eval #(
    .N(4),
    .DEFAULT_TT(16'h7EE0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_wr     (tt_wr),
    .tt_data   (tt_data),
    .eval_in   (eval_in),
    .eval_out  (eval_out),
    .start     (start),
    .skip_zeros(skip_zeros),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value),
    .done      (done),
    .ones_count(ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one sweep; returns in the done cycle (not yet advanced past it).
  task automatic run_sweep(input logic skip, input int ready_pct, input int wr_at,
                           output int done_cyc, output int ones);
    int   cyc;
    logic held;
    logic [3:0] h_idx;
    logic h_val;
    beats.delete();
    held     = 1'b0;
    h_idx    = '0;
    h_val    = 1'b0;
    done_cyc = -1;
    start      = 1'b1;
    skip_zeros = skip;
    tick();
    start = 1'b0;
    tt_wr = 1'b0;
    cyc   = 1;
    while (cyc <= 300 && done_cyc < 0) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (wr_at >= 0 && out_valid && out_index == wr_at[3:0]) begin
        tt_wr   = 1'b1;
        tt_data = 16'h0000;
      end else begin
        tt_wr = 1'b0;
      end
      if (held) begin
        check("hold_index", 32'(out_index), 32'(h_idx));
        check("hold_value", 32'(out_value), 32'(h_val));
      end
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (out_valid && out_ready) beats.push_back({out_index, out_value});
        held  = out_valid && !out_ready;
        h_idx = out_index;
        h_val = out_value;
        tick();
        cyc++;
      end
    end
    tt_wr = 1'b0;
    if (done_cyc < 0) check("sweep_timeout", 32'd0, 32'd1);
    ones = int'(ones_count);
  endtask

  // Expected stream derived from the known table contents.
  task automatic check_beats(input string name, input logic skip, input logic [15:0] tt);
    beat_t exp_q[$];
    for (int i = 0; i < 16; i++) begin
      if (!skip || tt[i]) exp_q.push_back({4'(i), tt[i]});
    end
    check({name, "_beat_count"}, 32'(beats.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      check({name, "_beat_idx"}, 32'(beats[i].idx), 32'(exp_q[i].idx));
      check({name, "_beat_val"}, 32'(beats[i].val), 32'(exp_q[i].val));
    end
  endtask

  initial begin
    eval_vec_t vecs[16];
    int dc;
    int ones;
    int guard;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    tt_wr      = 1'b0;
    tt_data    = '0;
    eval_in    = '0;
    start      = 1'b0;
    skip_zeros = 1'b0;
    out_ready  = 1'b0;

    // 16'h7EE0: on-set {5,6,7,9,10,11,12,13,14}
    vecs = '{'{4'd0, 1'b0}, '{4'd1, 1'b0}, '{4'd2, 1'b0}, '{4'd3, 1'b0},
             '{4'd4, 1'b0}, '{4'd5, 1'b1}, '{4'd6, 1'b1}, '{4'd7, 1'b1},
             '{4'd8, 1'b0}, '{4'd9, 1'b1}, '{4'd10, 1'b1}, '{4'd11, 1'b1},
             '{4'd12, 1'b1}, '{4'd13, 1'b1}, '{4'd14, 1'b1}, '{4'd15, 1'b0}};

    tick();
    tick();
    check("rst_eval_out", 32'(eval_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      eval_in = vecs[i].in;
      tick();
      check($sformatf("eval_%0d", vecs[i].in), 32'(eval_out), 32'(vecs[i].exp));
    end

    // Full sweep, ready always high.
    run_sweep(1'b0, 100, -1, dc, ones);
    check("m0_done_cycle", 32'(dc), 32'd17);
    check("m0_ones", 32'(ones), 32'd9);
    check("m0_busy_in_done", 32'(busy), 32'd1);
    check_beats("m0", 1'b0, 16'h7EE0);
    // Start during DONE must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_pulse_len", 32'(done), 32'd0);
    check("start_in_done_ignored", 32'(busy), 32'd0);
    check("ones_hold", 32'(ones_count), 32'd9);
    tick();

    // On-set sweep.
    run_sweep(1'b1, 100, -1, dc, ones);
    check("m1_done_cycle", 32'(dc), 32'd17);
    check("m1_ones", 32'(ones), 32'd9);
    check_beats("m1", 1'b1, 16'h7EE0);
    tick();
    tick();

    // Backpressure at 40% ready.
    run_sweep(1'b0, 40, -1, dc, ones);
    check("bp_ones", 32'(ones), 32'd9);
    check_beats("bp", 1'b0, 16'h7EE0);
    tick();
    tick();

    // Write together with start: sweep sees the new table.
    tt_wr   = 1'b1;
    tt_data = 16'hFFFF;
    run_sweep(1'b0, 100, -1, dc, ones);
    check("wr_start_ones", 32'(ones), 32'd16);
    tick();
    tt_wr   = 1'b1;
    tt_data = 16'h7EE0;
    tick();
    tt_wr = 1'b0;

    // Write during sweep is ignored.
    run_sweep(1'b0, 100, 3, dc, ones);
    check("locked_ones", 32'(ones), 32'd9);
    tick();
    eval_in = 4'd12;
    tick();
    check("locked_eval_12", 32'(eval_out), 32'd1);
    eval_in = 4'd8;
    tick();
    check("locked_eval_8", 32'(eval_out), 32'd0);

    // Reset in the middle of a sweep at index 7.
    out_ready  = 1'b1;
    start      = 1'b1;
    skip_zeros = 1'b0;
    tick();
    start = 1'b0;
    guard = 0;
    while (out_index != 4'd7 && guard < 40) begin
      tick();
      guard++;
    end
    check("mid_reach_idx7", 32'(out_index), 32'd7);
    rst     = 1'b1;
    eval_in = 4'd5;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ones", 32'(ones_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_eval_5", 32'(eval_out), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
